// File: rtl/config_loader_if.sv
// Word handshake between a configuration word source and config_loader.
// The master drives word_valid/word_data; the slave (config_loader) drives word_ready.
interface config_loader_if #(
    parameter int WORD_W = 32
);
    logic              word_valid;
    logic [WORD_W-1:0] word_data;
    logic              word_ready;

    modport master (output word_valid, output word_data, input word_ready);
    modport slave  (input word_valid, input word_data, output word_ready);
endinterface

// File: rtl/config_loader.sv
// config_loader: feeds the config_tile shift chain from a stream of configuration
// words. Each word is shifted out LSB-first, one bit per clock, until exactly
// CHAIN_LEN bits have gone out; a single-cycle set pulse then latches the chain.
// Bits of the final word beyond CHAIN_LEN are dropped.
//
// Optional feature macro: CONFIG_LOADER_PARITY_EN
//   When defined, one extra parity word is taken after the data; its bit 0 must
//   equal the XOR of all shifted bits. On mismatch no set pulse is issued and err
//   is raised until the next accepted start. When undefined, err is tied low.
//
// state   | meaning
// IDLE    | after reset, waiting for start
// FETCH   | word_ready high, waiting for the next data word (chain holds)
// SHIFT   | shifting the held word onto the chain, one bit per cycle
// CHECK   | (parity build only) waiting for the parity word
// SET     | one-cycle set pulse to the chain
// DONE    | load complete, waiting for a new start
module config_loader #(
    parameter int WORD_W    = 32,
    parameter int CHAIN_LEN = 64
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            start_i,
    config_loader_if.slave  word_if,
    output logic            cfg_shift_en_o,
    output logic            cfg_shift_out_o,
    output logic            cfg_set_o,
    output logic            busy_o,
    output logic            done_o,
    output logic            err_o
);

    localparam int CNT_W  = $clog2(CHAIN_LEN + 1);
    localparam int WCNT_W = $clog2(WORD_W + 1);

`ifdef CONFIG_LOADER_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_SHIFT, S_CHECK, S_SET, S_DONE} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_SHIFT, S_SET, S_DONE} state_t;
`endif

    state_t              state_q;
    logic [WORD_W-1:0]   sh_q;          // remaining bits of the current word, next bit at [0]
    logic [WCNT_W-1:0]   wbits_q;       // bits of the current word still to shift (incl. the one on the output)
    logic [CNT_W-1:0]    bits_left_q;   // chain bits still to shift (incl. the one on the output)
    logic                ready_q;
    logic                shift_en_q;
    logic                shift_out_q;
    logic                set_q;
    logic                busy_q;
    logic                done_q;
`ifdef CONFIG_LOADER_PARITY_EN
    logic                par_q;
    logic                err_q;
`endif

    logic accept;
    assign accept = ready_q & word_if.word_valid;

    // Sequencer with all outputs registered alongside the state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            sh_q        <= '0;
            wbits_q     <= '0;
            bits_left_q <= '0;
            ready_q     <= 1'b0;
            shift_en_q  <= 1'b0;
            shift_out_q <= 1'b0;
            set_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef CONFIG_LOADER_PARITY_EN
            par_q       <= 1'b0;
            err_q       <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start_i) begin
                        state_q     <= S_FETCH;
                        ready_q     <= 1'b1;
                        busy_q      <= 1'b1;
                        done_q      <= 1'b0;
                        bits_left_q <= CNT_W'(CHAIN_LEN);
`ifdef CONFIG_LOADER_PARITY_EN
                        par_q       <= 1'b0;
                        err_q       <= 1'b0;
`endif
                    end
                end
                S_FETCH: begin
                    if (accept) begin
                        state_q     <= S_SHIFT;
                        ready_q     <= 1'b0;
                        shift_en_q  <= 1'b1;
                        shift_out_q <= word_if.word_data[0];
                        sh_q        <= word_if.word_data >> 1;
                        wbits_q     <= WCNT_W'(WORD_W);
                    end
                end
                S_SHIFT: begin
                    bits_left_q <= bits_left_q - CNT_W'(1);
                    wbits_q     <= wbits_q - WCNT_W'(1);
`ifdef CONFIG_LOADER_PARITY_EN
                    par_q       <= par_q ^ shift_out_q;
`endif
                    if (bits_left_q == CNT_W'(1)) begin
                        shift_en_q  <= 1'b0;
                        shift_out_q <= 1'b0;
`ifdef CONFIG_LOADER_PARITY_EN
                        state_q     <= S_CHECK;
                        ready_q     <= 1'b1;
`else
                        state_q     <= S_SET;
                        set_q       <= 1'b1;
`endif
                    end else if (wbits_q == WCNT_W'(1)) begin
                        // Word exhausted: hold the chain while the next word is fetched.
                        state_q     <= S_FETCH;
                        ready_q     <= 1'b1;
                        shift_en_q  <= 1'b0;
                        shift_out_q <= 1'b0;
                    end else begin
                        shift_out_q <= sh_q[0];
                        sh_q        <= sh_q >> 1;
                    end
                end
`ifdef CONFIG_LOADER_PARITY_EN
                S_CHECK: begin
                    if (accept) begin
                        ready_q <= 1'b0;
                        if (word_if.word_data[0] == par_q) begin
                            state_q <= S_SET;
                            set_q   <= 1'b1;
                        end else begin
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                        end
                    end
                end
`endif
                S_SET: begin
                    state_q <= S_DONE;
                    set_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign word_if.word_ready = ready_q;
    assign cfg_shift_en_o     = shift_en_q;
    assign cfg_shift_out_o    = shift_out_q;
    assign cfg_set_o          = set_q;
    assign busy_o             = busy_q;
    assign done_o             = done_q;
`ifdef CONFIG_LOADER_PARITY_EN
    assign err_o              = err_q;
`else
    assign err_o              = 1'b0;
`endif

endmodule

// File: tb/tb_config_loader.sv
// Bench for config_loader: dut_a (WORD_W=8, CHAIN_LEN=20) and dut_b (WORD_W=8,
// CHAIN_LEN=8). Expected serial events (bit 0/1, or 2 for a set pulse) are
// queued by the stimulus and consumed by per-DUT monitors on the falling edge.
module tb_config_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic start_a, start_b;
    logic en_a, out_a, set_a, busy_a, done_a, err_a;
    logic en_b, out_b, set_b, busy_b, done_b, err_b;

    config_loader_if #(.WORD_W(8)) if_a ();
    config_loader_if #(.WORD_W(8)) if_b ();

    config_loader #(.WORD_W(8), .CHAIN_LEN(20)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start_a), .word_if(if_a.slave),
        .cfg_shift_en_o(en_a), .cfg_shift_out_o(out_a), .cfg_set_o(set_a),
        .busy_o(busy_a), .done_o(done_a), .err_o(err_a)
    );

    config_loader #(.WORD_W(8), .CHAIN_LEN(8)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start_b), .word_if(if_b.slave),
        .cfg_shift_en_o(en_b), .cfg_shift_out_o(out_b), .cfg_set_o(set_b),
        .busy_o(busy_b), .done_o(done_b), .err_o(err_b)
    );

`ifdef CONFIG_LOADER_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    int checks = 0;
    int errors = 0;
    int qa[$];
    int qb[$];

    // 0xA5, 0x3C, 0x0F shifted LSB-first, 20 bits.
    int exp_stream [20] = '{1,0,1,0,0,1,0,1, 0,0,1,1,1,1,0,0, 1,1,1,1};
    logic [7:0] words_a [3] = '{8'hA5, 8'h3C, 8'h0F};
    logic [7:0] par_word_a = 8'h00;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Monitor for dut_a.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && (en_a === 1'b1 || set_a === 1'b1)) begin
            if (qa.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL a_unexpected_event: got en=%0b set=%0b expected no activity", en_a, set_a);
            end else begin
                check("a_stream", (en_a === 1'b1) ? {31'd0, out_a} : 32'd2, qa.pop_front());
            end
        end
    end

    // Monitor for dut_b.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && (en_b === 1'b1 || set_b === 1'b1)) begin
            if (qb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL b_unexpected_event: got en=%0b set=%0b expected no activity", en_b, set_b);
            end else begin
                check("b_stream", (en_b === 1'b1) ? {31'd0, out_b} : 32'd2, qb.pop_front());
            end
        end
    end

    task automatic push_a(input int nbits, input bit with_set);
        for (int i = 0; i < nbits; i++) qa.push_back(exp_stream[i]);
        if (with_set) qa.push_back(2);
    endtask

    task automatic pulse_start_a;
        @(posedge clk); #1 start_a = 1'b1;
        @(posedge clk); #1 start_a = 1'b0;
    endtask

    task automatic pulse_start_b;
        @(posedge clk); #1 start_b = 1'b1;
        @(posedge clk); #1 start_b = 1'b0;
    endtask

    task automatic send_word_a(input logic [7:0] w, output bit ok);
        if_a.word_valid = 1'b1;
        if_a.word_data  = w;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (if_a.word_ready === 1'b1) begin ok = 1'b1; break; end
        end
        if (!ok) check("a_word_ready_timeout", 0, 1);
        else begin @(posedge clk); #1 if_a.word_valid = 1'b0; end
    endtask

    task automatic send_word_b(input logic [7:0] w, output bit ok);
        if_b.word_valid = 1'b1;
        if_b.word_data  = w;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (if_b.word_ready === 1'b1) begin ok = 1'b1; break; end
        end
        if (!ok) check("b_word_ready_timeout", 0, 1);
        else begin @(posedge clk); #1 if_b.word_valid = 1'b0; end
    endtask

    task automatic wait_done(input bit sel_b, output int busy_cycles);
        bit ok;
        ok = 1'b0;
        busy_cycles = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if ((sel_b ? busy_b : busy_a) === 1'b1) busy_cycles++;
            if ((sel_b ? done_b : done_a) === 1'b1) begin ok = 1'b1; break; end
        end
        if (!ok) check(sel_b ? "b_done_timeout" : "a_done_timeout", 0, 1);
    endtask

    // mode 0: back-to-back words, 1: 5-cycle stall after word 0, 2: start pulse during SHIFT
    task automatic run_load_a(input int mode, output int busy_cycles);
        fork
            begin
                bit ok;
                ok = 1'b1;
                for (int w = 0; w < 3 + PAR && ok; w++) begin
                    send_word_a((w < 3) ? words_a[w] : par_word_a, ok);
                    if (ok && w == 0 && mode == 1) begin
                        bit seen;
                        seen = 1'b0;
                        for (int i = 0; i < 50; i++) begin
                            @(negedge clk);
                            if (if_a.word_ready === 1'b1) begin seen = 1'b1; break; end
                        end
                        check("a_stall_reached_fetch", {31'd0, seen}, 1);
                        check("a_stall_shift_en", {31'd0, en_a}, 0);
                        for (int k = 1; k < 5; k++) begin
                            @(negedge clk);
                            check("a_stall_shift_en", {31'd0, en_a}, 0);
                        end
                        @(posedge clk); #1;
                    end
                    if (ok && w == 0 && mode == 2) begin
                        start_a = 1'b1;
                        @(posedge clk); #1 start_a = 1'b0;
                        @(negedge clk);
                        check("a_start_in_shift_busy", {31'd0, busy_a}, 1);
                        check("a_start_in_shift_ready", {31'd0, if_a.word_ready}, 0);
                    end
                end
            end
            begin
                wait_done(1'b0, busy_cycles);
            end
        join
    endtask

    task automatic finish_checks_a(input string tag, input int busy_cycles, input int exp_busy, input logic exp_err);
        check({tag, "_busy_cycles"}, busy_cycles, exp_busy);
        check({tag, "_done"}, {31'd0, done_a}, 1);
        check({tag, "_busy_after"}, {31'd0, busy_a}, 0);
        check({tag, "_err"}, {31'd0, err_a}, {31'd0, exp_err});
        check({tag, "_queue_left"}, qa.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bc;
        int nsh;
        bit ok;
        rst_n = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        if_a.word_valid = 1'b0; if_a.word_data = '0;
        if_b.word_valid = 1'b0; if_b.word_data = '0;

        // Reset state
        #12;
        check("rst_shift_en", {31'd0, en_a}, 0);
        check("rst_shift_out", {31'd0, out_a}, 0);
        check("rst_set", {31'd0, set_a}, 0);
        check("rst_busy", {31'd0, busy_a}, 0);
        check("rst_done", {31'd0, done_a}, 0);
        check("rst_err", {31'd0, err_a}, 0);
        check("rst_ready", {31'd0, if_a.word_ready}, 0);
        @(negedge clk); rst_n = 1'b1;

        // Test 1: valid high already in IDLE, start taken, word not accepted in IDLE
        if_a.word_valid = 1'b1; if_a.word_data = 8'hA5;
        push_a(20, 1'b1);
        @(negedge clk);
        check("t1_idle_ready", {31'd0, if_a.word_ready}, 0);
        pulse_start_a();
        run_load_a(0, bc);
        finish_checks_a("t1", bc, 24 + PAR, 1'b0);

        // Test 2: 5-cycle stall between words 0 and 1
        push_a(20, 1'b1);
        pulse_start_a();
        check("t2_done_cleared", {31'd0, done_a}, 0);
        run_load_a(1, bc);
        finish_checks_a("t2", bc, 29 + PAR, 1'b0);

        // Test 3: start during SHIFT is ignored
        push_a(20, 1'b1);
        pulse_start_a();
        run_load_a(2, bc);
        finish_checks_a("t3", bc, 24 + PAR, 1'b0);

        // Test 4: reset after 7 shifts, then full reload
        push_a(7, 1'b0);
        if_a.word_valid = 1'b1; if_a.word_data = 8'hA5;
        pulse_start_a();
        nsh = 0;
        for (int i = 0; i < 100 && nsh < 7; i++) begin
            @(negedge clk);
            if (en_a === 1'b1) nsh++;
        end
        check("t4_shifts_before_reset", nsh, 7);
        #1 rst_n = 1'b0;
        if_a.word_valid = 1'b0;
        #1;
        check("t4_rst_shift_en", {31'd0, en_a}, 0);
        check("t4_rst_shift_out", {31'd0, out_a}, 0);
        check("t4_rst_set", {31'd0, set_a}, 0);
        check("t4_rst_busy", {31'd0, busy_a}, 0);
        check("t4_rst_ready", {31'd0, if_a.word_ready}, 0);
        check("t4_queue_left", qa.size(), 0);
        @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        check("t4_idle_done", {31'd0, done_a}, 0);
        push_a(20, 1'b1);
        pulse_start_a();
        run_load_a(0, bc);
        finish_checks_a("t4_reload", bc, 24 + PAR, 1'b0);

`ifdef CONFIG_LOADER_PARITY_EN
        // Test 6b: wrong parity word -> no set, err, done
        par_word_a = 8'h01;
        push_a(20, 1'b0);
        pulse_start_a();
        run_load_a(0, bc);
        finish_checks_a("t6_bad_par", bc, 24, 1'b1);
        // err clears on the next accepted start
        par_word_a = 8'h00;
        push_a(20, 1'b1);
        pulse_start_a();
        check("t6_err_cleared", {31'd0, err_a}, 0);
        run_load_a(0, bc);
        finish_checks_a("t6_good_par", bc, 25, 1'b0);
`endif

        // Test 5: CHAIN_LEN == WORD_W, single word 0xFF
        for (int i = 0; i < 8; i++) qb.push_back(1);
        qb.push_back(2);
        pulse_start_b();
        fork
            begin
                send_word_b(8'hFF, ok);
                if (ok && PAR == 1) send_word_b(8'h00, ok);
            end
            begin
                wait_done(1'b1, bc);
            end
        join
        check("t5_busy_cycles", bc, 10 + PAR);
        check("t5_done", {31'd0, done_b}, 1);
        check("t5_err", {31'd0, err_b}, 0);
        check("t5_queue_left", qb.size(), 0);

        repeat (3) @(negedge clk);
        check("end_queue_a", qa.size(), 0);
        check("end_queue_b", qb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
